// File: rtl/conv_frame_loader_pkg.sv
// Shared constants for the convolution frame loader: state encoding, default
// geometry and the element-counter width helper.
package conv_frame_loader_pkg;

    // Loader states; two bits keep the encoding compatible with older consumers.
    localparam logic [1:0] S_KERNEL = 2'd0;
    localparam logic [1:0] S_FRAME  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    // Default geometry: element width, frame edge, kernel edge.
    localparam int unsigned DEF_B = 8;
    localparam int unsigned DEF_A = 5;
    localparam int unsigned DEF_C = 3;

    // Counter must index every frame element; the kernel is never larger.
    function automatic int unsigned cnt_width(input int unsigned edge_len);
        return $clog2(edge_len * edge_len + 1);
    endfunction

    // Element totals for the default geometry.
    localparam int unsigned DEF_MAT_ELEMS = DEF_A * DEF_A;
    localparam int unsigned DEF_KER_ELEMS = DEF_C * DEF_C;
    localparam int unsigned DEF_CNT_W     = cnt_width(DEF_A);

endpackage

// File: rtl/conv_frame_loader.sv
// Streams a c*c kernel followed by repeated a*a frames over valid/ready and
// packs them row-major into flat buses; a completed frame is held stable until
// the consumer acknowledges it with frame_ready. Requires c <= a.
module conv_frame_loader
    import conv_frame_loader_pkg::*;
#(
    parameter int unsigned b = DEF_B,
    parameter int unsigned a = DEF_A,
    parameter int unsigned c = DEF_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [b-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             kernel_reload,
    input  logic             frame_ready,
    output logic             frame_valid,
    output logic [a*a*b-1:0] matrix_out,
    output logic [c*c*b-1:0] kernel_out,
    output logic [15:0]      frame_count
);

    localparam int unsigned MAT_N = a * a;
    localparam int unsigned KER_N = c * c;
    localparam int unsigned CW    = cnt_width(a);

    localparam logic [CW-1:0] MAT_LAST = CW'(MAT_N - 1);
    localparam logic [CW-1:0] KER_LAST = CW'(KER_N - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [a*a*b-1:0]   matrix_q, matrix_d;
    logic [c*c*b-1:0]   kernel_q, kernel_d;
    logic [15:0]        count_q, count_d;

    logic               beat;
    logic [1:0]         eff_state;

    // Handshake and output view of the held registers.
    always_comb begin
        in_ready    = (state_q != S_HOLD);
        frame_valid = (state_q == S_HOLD);
        matrix_out  = matrix_q;
        kernel_out  = kernel_q;
        frame_count = count_q;
    end

    // Next-state: reload redirection, element writes, frame hand-off.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        matrix_d = matrix_q;
        kernel_d = kernel_q;
        count_d  = count_q;
        beat     = in_valid && in_ready;

        // A reload at a frame boundary switches straight to kernel loading, so a
        // beat on the same edge already counts as kernel element 0; mid-frame it
        // is deferred until the frame has been handed off.
        eff_state = state_q;
        if (state_q == S_FRAME && kernel_reload) begin
            if (cnt_q == '0) begin
                eff_state = S_KERNEL;
            end else begin
                pend_d = 1'b1;
            end
        end
        state_d = eff_state;

        unique case (eff_state)
            S_KERNEL: begin
                if (beat) begin
                    for (int unsigned i = 0; i < KER_N; i++) begin
                        if (cnt_q == CW'(i)) begin
                            kernel_d[i*b +: b] = in_data;
                        end
                    end
                    if (cnt_q == KER_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FRAME;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_FRAME: begin
                // Writes land directly in the output bus; only meaningful once
                // frame_valid rises.
                if (beat) begin
                    for (int unsigned i = 0; i < MAT_N; i++) begin
                        if (cnt_q == CW'(i)) begin
                            matrix_d[i*b +: b] = in_data;
                        end
                    end
                    if (cnt_q == MAT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_HOLD: begin
                if (frame_ready) begin
                    count_d = count_q + 16'd1;
                    if (pend_q || kernel_reload) begin
                        state_d = S_KERNEL;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_FRAME;
                    end
                end else if (kernel_reload) begin
                    pend_d = 1'b1;
                end
            end

            default: begin
                state_d = S_KERNEL;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; synchronous reset overrides any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_KERNEL;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            matrix_q <= '0;
            kernel_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            matrix_q <= matrix_d;
            kernel_q <= kernel_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: kernel/frame loading, hold behaviour,
// gapped input, kernel reload (deferred and immediate), reset mid-load and
// full-rate streaming.
module tb_conv_frame_loader;

    localparam int A = 5;
    localparam int B = 8;
    localparam int C = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [B-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic               kernel_reload;
    logic               frame_ready;
    logic               frame_valid;
    logic [A*A*B-1:0]   matrix_out;
    logic [C*C*B-1:0]   kernel_out;
    logic [15:0]        frame_count;

    int n_vec = 0;
    int n_err = 0;

    logic [B-1:0] exp_k [C*C];
    logic [B-1:0] exp_m [A*A];

    always #5 clk = ~clk;

    conv_frame_loader #(.b(B), .a(A), .c(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .kernel_reload(kernel_reload),
        .frame_ready  (frame_ready),
        .frame_valid  (frame_valid),
        .matrix_out   (matrix_out),
        .kernel_out   (kernel_out),
        .frame_count  (frame_count)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [A*A*B-1:0] mat_bus();
        logic [A*A*B-1:0] r;
        for (int i = 0; i < A*A; i++) r[i*B +: B] = exp_m[i];
        return r;
    endfunction

    function automatic logic [C*C*B-1:0] ker_bus();
        logic [C*C*B-1:0] r;
        for (int i = 0; i < C*C; i++) r[i*B +: B] = exp_k[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and wait (bounded) until it is accepted; in_valid stays high.
    task automatic send(input logic [B-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 256'(in_ready), 256'(1));
    endtask

    task automatic send_kernel(input logic [B-1:0] base);
        for (int i = 0; i < C*C; i++) begin
            exp_k[i] = base + B'(i);
            send(base + B'(i));
        end
    endtask

    task automatic send_frame(input logic [B-1:0] base);
        for (int i = 0; i < A*A; i++) begin
            exp_m[i] = base + B'(i);
            send(base + B'(i));
        end
    endtask

    task automatic release_frame();
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  cyc;
        int  beat_i;
        int  highs;
        int  pos [3];
        logic hit;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; kernel_reload = 1'b0; frame_ready = 1'b0;
        tick();
        rst = 1'b0;
        foreach (exp_k[i]) exp_k[i] = '0;
        foreach (exp_m[i]) exp_m[i] = '0;

        // Reset state
        check("rst_fv",     256'(frame_valid), 256'(0));
        check("rst_ready",  256'(in_ready),    256'(1));
        check("rst_mat",    256'(matrix_out),  256'(0));
        check("rst_ker",    256'(kernel_out),  256'(0));
        check("rst_count",  256'(frame_count), 256'(0));

        // Kernel 1..9, frame 1..25, held
        send_kernel(8'd1);
        check("ker_fv_low", 256'(frame_valid), 256'(0));
        for (int i = 0; i < A*A - 1; i++) begin
            exp_m[i] = 8'(i + 1);
            send(8'(i + 1));
        end
        check("fv_before_last", 256'(frame_valid), 256'(0));
        exp_m[24] = 8'd25;
        send(8'd25);
        check("fv_rise",    256'(frame_valid),        256'(1));
        check("ker_lo",     256'(kernel_out[7:0]),    256'(8'd1));
        check("ker_hi",     256'(kernel_out[71:64]),  256'(8'd9));
        check("mat_last",   256'(matrix_out[199:192]), 256'(8'd25));
        check("mat_full",   256'(matrix_out),         256'(mat_bus()));
        check("hold_ready", 256'(in_ready),           256'(0));

        // Hold 4 cycles with a competing word offered; nothing may change
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_fv",  256'(frame_valid), 256'(1));
            check("hold_mat", 256'(matrix_out),  256'(mat_bus()));
        end
        check("hold_ker", 256'(kernel_out), 256'(ker_bus()));
        release_frame();
        check("rel_fv",    256'(frame_valid), 256'(0));
        check("rel_count", 256'(frame_count), 256'(1));
        check("rel_ready", 256'(in_ready),    256'(1));
        check("rel_mat",   256'(matrix_out),  256'(mat_bus()));

        // Gapped input: in_valid every other cycle
        acc = 0;
        cyc = 0;
        while (acc < A*A && cyc < 200) begin
            in_valid = (cyc % 2 == 0);
            in_data  = 8'(100 + acc);
            hit = in_valid && in_ready;
            if (hit) begin
                exp_m[acc] = in_data;
                acc++;
            end
            tick();
            cyc++;
            if (hit && acc == 3)  check("gap_partial_mat", 256'(matrix_out), 256'(mat_bus()));
            if (hit && acc == 24) check("gap_fv_24",       256'(frame_valid), 256'(0));
        end
        in_valid = 1'b0;
        check("gap_fv",     256'(frame_valid), 256'(1));
        check("gap_cycles", 256'(cyc),         256'(49));
        check("gap_mat",    256'(matrix_out),  256'(mat_bus()));
        release_frame();
        check("gap_count",  256'(frame_count), 256'(2));

        // Deferred reload requested at frame beat 10
        for (int i = 0; i < A*A; i++) begin
            exp_m[i] = 8'(8'h30 + i);
            kernel_reload = (i == 9);
            send(8'(8'h30 + i));
            kernel_reload = 1'b0;
        end
        check("rl_fv",    256'(frame_valid), 256'(1));
        check("rl_mat",   256'(matrix_out),  256'(mat_bus()));
        check("rl_ker_old", 256'(kernel_out), 256'(ker_bus()));
        release_frame();
        check("rl_count", 256'(frame_count), 256'(3));
        send_kernel(8'hA0);
        check("rl_ker_new", 256'(kernel_out), 256'(ker_bus()));
        check("rl_fv_low",  256'(frame_valid), 256'(0));
        send_frame(8'h60);
        check("rl_frame_fv",  256'(frame_valid), 256'(1));
        check("rl_frame_mat", 256'(matrix_out),  256'(mat_bus()));
        release_frame();

        // Immediate reload at a frame boundary: same-edge beat is kernel element 0
        kernel_reload = 1'b1;
        exp_k[0] = 8'hB0;
        send(8'hB0);
        kernel_reload = 1'b0;
        for (int i = 1; i < C*C; i++) begin
            exp_k[i] = 8'(8'hB0 + i);
            send(8'(8'hB0 + i));
        end
        check("imm_ker",   256'(kernel_out), 256'(ker_bus()));
        send_frame(8'hC0);
        check("imm_fv",    256'(frame_valid), 256'(1));
        check("imm_mat",   256'(matrix_out),  256'(mat_bus()));
        release_frame();
        check("imm_count", 256'(frame_count), 256'(5));

        // Reset asserted on frame beat 12
        for (int i = 0; i < 11; i++) send(8'(8'h70 + i));
        in_valid = 1'b1;
        in_data  = 8'h7B;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        foreach (exp_k[i]) exp_k[i] = '0;
        foreach (exp_m[i]) exp_m[i] = '0;
        check("mrst_fv",    256'(frame_valid), 256'(0));
        check("mrst_mat",   256'(matrix_out),  256'(0));
        check("mrst_ker",   256'(kernel_out),  256'(0));
        check("mrst_count", 256'(frame_count), 256'(0));
        check("mrst_ready", 256'(in_ready),    256'(1));
        send_kernel(8'h10);
        check("mrst_ker_load", 256'(kernel_out), 256'(ker_bus()));
        check("mrst_mat_keep", 256'(matrix_out), 256'(0));

        // Full rate: frame_ready high, continuous valid, 3 frames
        frame_ready = 1'b1;
        in_valid    = 1'b1;
        beat_i = 0;
        highs  = 0;
        for (int k = 0; k < 3; k++) pos[k] = 0;
        for (int cy = 1; cy <= 78; cy++) begin
            in_data = 8'(8'h40 + beat_i);
            hit = in_ready;
            if (hit) exp_m[beat_i % (A*A)] = in_data;
            tick();
            if (hit) beat_i++;
            if (frame_valid) begin
                if (highs < 3) pos[highs] = cy;
                highs++;
                check("rate_mat", 256'(matrix_out), 256'(mat_bus()));
            end
        end
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        check("rate_highs",  256'(highs),        256'(3));
        check("rate_first",  256'(pos[0]),       256'(25));
        check("rate_per1",   256'(pos[1] - pos[0]), 256'(26));
        check("rate_per2",   256'(pos[2] - pos[1]), 256'(26));
        check("rate_count",  256'(frame_count),  256'(3));
        check("rate_fv_end", 256'(frame_valid),  256'(0));
        check("rate_ker",    256'(kernel_out),   256'(ker_bus()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
